// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA-style raster timing generator.
// Free-running horizontal/vertical counters drive sync, active and
// data-enable strobes, pixel coordinates and line/frame/irq pulses.
// All timing values live in shadow registers that are refreshed only at
// a frame boundary (or at once while idle), so a new mode never tears.
module vga_timing_gen #(
    parameter int   CW          = 12,
    parameter logic RESET_POL_H = 1'b0,
    parameter logic RESET_POL_V = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enabled,
    input  logic          cfg_update,
    input  logic [CW-1:0] h_total,
    input  logic [CW-1:0] h_sync_start,
    input  logic [CW-1:0] h_sync_end,
    input  logic [CW-1:0] h_active_start,
    input  logic [CW-1:0] h_active_end,
    input  logic          h_pol,
    input  logic [CW-1:0] v_total,
    input  logic [CW-1:0] v_sync_start,
    input  logic [CW-1:0] v_sync_end,
    input  logic [CW-1:0] v_active_start,
    input  logic [CW-1:0] v_active_end,
    input  logic          v_pol,
    input  logic [CW-1:0] irq_line,
    output logic          h_sync,
    output logic          v_sync,
    output logic          h_active,
    output logic          v_active,
    output logic          de,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          line_start,
    output logic          frame_start,
    output logic          line_irq,
    output logic          cfg_pending
);

    localparam logic [CW-1:0] ONE = CW'(1);

    // Window indices for the shared half-open compare array
    localparam int WIN_HS = 0;
    localparam int WIN_HA = 1;
    localparam int WIN_VS = 2;
    localparam int WIN_VA = 3;
    localparam int NWIN   = 4;

    // Shadow copies of the timing inputs (the values actually in use)
    logic [CW-1:0] r_h_total_s;
    logic [CW-1:0] r_h_sync_start_s;
    logic [CW-1:0] r_h_sync_end_s;
    logic [CW-1:0] r_h_active_start_s;
    logic [CW-1:0] r_h_active_end_s;
    logic          r_h_pol_s;
    logic [CW-1:0] r_v_total_s;
    logic [CW-1:0] r_v_sync_start_s;
    logic [CW-1:0] r_v_sync_end_s;
    logic [CW-1:0] r_v_active_start_s;
    logic [CW-1:0] r_v_active_end_s;
    logic          r_v_pol_s;
    logic [CW-1:0] r_irq_line_s;
    logic          r_cfg_pending;

    // Raster position
    logic [CW-1:0] r_hc;
    logic [CW-1:0] r_vc;

    // Registered outputs
    logic          r_h_sync;
    logic          r_v_sync;
    logic          r_h_active;
    logic          r_v_active;
    logic          r_de;
    logic [CW-1:0] r_pixel_x;
    logic [CW-1:0] r_pixel_y;
    logic          r_line_start;
    logic          r_frame_start;
    logic          r_line_irq;

    // Counter wrap and frame boundary detection. Totals of 0 or 1 pin the
    // counter at 0, which makes every clock a wrap; the >= compare keeps
    // the counter from running away if it ever sits beyond the total.
    logic w_h_last;
    logic w_v_last;
    logic w_frame_last;
    logic w_load;

    assign w_h_last     = (r_h_total_s <= ONE) || (r_hc >= (r_h_total_s - ONE));
    assign w_v_last     = (r_v_total_s <= ONE) || (r_vc >= (r_v_total_s - ONE));
    assign w_frame_last = w_h_last && w_v_last;

    // A new request counts on the same clock it arrives; while idle there
    // is no frame to protect, so the load happens straight away.
    assign w_load = (r_cfg_pending || cfg_update) && (!enabled || w_frame_last);

    // Half-open [start, end) windows; start >= end can never match.
    logic [CW-1:0] w_win_pos   [NWIN];
    logic [CW-1:0] w_win_start [NWIN];
    logic [CW-1:0] w_win_end   [NWIN];
    logic [NWIN-1:0] w_win_in;

    assign w_win_pos[WIN_HS]   = r_hc;
    assign w_win_start[WIN_HS] = r_h_sync_start_s;
    assign w_win_end[WIN_HS]   = r_h_sync_end_s;
    assign w_win_pos[WIN_HA]   = r_hc;
    assign w_win_start[WIN_HA] = r_h_active_start_s;
    assign w_win_end[WIN_HA]   = r_h_active_end_s;
    assign w_win_pos[WIN_VS]   = r_vc;
    assign w_win_start[WIN_VS] = r_v_sync_start_s;
    assign w_win_end[WIN_VS]   = r_v_sync_end_s;
    assign w_win_pos[WIN_VA]   = r_vc;
    assign w_win_start[WIN_VA] = r_v_active_start_s;
    assign w_win_end[WIN_VA]   = r_v_active_end_s;

    genvar gi;
    generate
        for (gi = 0; gi < NWIN; gi++) begin : g_win
            assign w_win_in[gi] = (w_win_pos[gi] >= w_win_start[gi]) &&
                                  (w_win_pos[gi] <  w_win_end[gi]);
        end
    endgenerate

    logic w_de;
    assign w_de = w_win_in[WIN_HA] && w_win_in[WIN_VA];

    // Shadow register load at frame boundary or while idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_h_total_s        <= '0;
            r_h_sync_start_s   <= '0;
            r_h_sync_end_s     <= '0;
            r_h_active_start_s <= '0;
            r_h_active_end_s   <= '0;
            r_h_pol_s          <= RESET_POL_H;
            r_v_total_s        <= '0;
            r_v_sync_start_s   <= '0;
            r_v_sync_end_s     <= '0;
            r_v_active_start_s <= '0;
            r_v_active_end_s   <= '0;
            r_v_pol_s          <= RESET_POL_V;
            r_irq_line_s       <= '0;
        end else if (w_load) begin
            r_h_total_s        <= h_total;
            r_h_sync_start_s   <= h_sync_start;
            r_h_sync_end_s     <= h_sync_end;
            r_h_active_start_s <= h_active_start;
            r_h_active_end_s   <= h_active_end;
            r_h_pol_s          <= h_pol;
            r_v_total_s        <= v_total;
            r_v_sync_start_s   <= v_sync_start;
            r_v_sync_end_s     <= v_sync_end;
            r_v_active_start_s <= v_active_start;
            r_v_active_end_s   <= v_active_end;
            r_v_pol_s          <= v_pol;
            r_irq_line_s       <= irq_line;
        end
    end

    // Update-request flag: set by a request, cleared when the load lands
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cfg_pending <= 1'b0;
        end else if (w_load) begin
            r_cfg_pending <= 1'b0;
        end else if (cfg_update) begin
            r_cfg_pending <= 1'b1;
        end
    end

    // Horizontal/vertical raster counters, parked at origin while idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (!enabled) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (w_h_last) begin
            r_hc <= '0;
            r_vc <= w_v_last ? '0 : (r_vc + ONE);
        end else begin
            r_hc <= r_hc + ONE;
        end
    end

    // Output stage: one clock behind the counter value it describes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_h_sync      <= ~RESET_POL_H;
            r_v_sync      <= ~RESET_POL_V;
            r_h_active    <= 1'b0;
            r_v_active    <= 1'b0;
            r_de          <= 1'b0;
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_irq    <= 1'b0;
        end else if (!enabled) begin
            r_h_sync      <= ~r_h_pol_s;
            r_v_sync      <= ~r_v_pol_s;
            r_h_active    <= 1'b0;
            r_v_active    <= 1'b0;
            r_de          <= 1'b0;
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_irq    <= 1'b0;
        end else begin
            r_h_sync      <= w_win_in[WIN_HS] ? r_h_pol_s : ~r_h_pol_s;
            r_v_sync      <= w_win_in[WIN_VS] ? r_v_pol_s : ~r_v_pol_s;
            r_h_active    <= w_win_in[WIN_HA];
            r_v_active    <= w_win_in[WIN_VA];
            r_de          <= w_de;
            r_pixel_x     <= w_de ? (r_hc - r_h_active_start_s) : '0;
            r_pixel_y     <= w_de ? (r_vc - r_v_active_start_s) : '0;
            r_line_start  <= (r_hc == '0);
            r_frame_start <= (r_hc == '0) && (r_vc == '0);
            r_line_irq    <= (r_hc == '0) && (r_vc == r_irq_line_s);
        end
    end

    assign h_sync      = r_h_sync;
    assign v_sync      = r_v_sync;
    assign h_active    = r_h_active;
    assign v_active    = r_v_active;
    assign de          = r_de;
    assign pixel_x     = r_pixel_x;
    assign pixel_y     = r_pixel_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign line_irq    = r_line_irq;
    assign cfg_pending = r_cfg_pending;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a frame-position reference model runs
// beside the DUT and every sampled clock is compared against it, with
// per-scenario checks on line/frame periods, counts and boundaries.
module tb_vga_timing_gen;

    localparam int CW = 12;
    localparam logic [32:0] RESET_VEC = {2'b11, 31'b0};

    logic          clk = 1'b0;
    logic          reset;
    logic          enabled;
    logic          cfg_update;
    logic [CW-1:0] h_total, h_sync_start, h_sync_end, h_active_start, h_active_end;
    logic [CW-1:0] v_total, v_sync_start, v_sync_end, v_active_start, v_active_end;
    logic          h_pol, v_pol;
    logic [CW-1:0] irq_line;
    logic          h_sync, v_sync, h_active, v_active, de;
    logic [CW-1:0] pixel_x, pixel_y;
    logic          line_start, frame_start, line_irq, cfg_pending;

    int n_pass = 0;
    int n_total = 0;

    vga_timing_gen #(.CW(CW), .RESET_POL_H(1'b0), .RESET_POL_V(1'b0)) dut (
        .clk(clk), .reset(reset), .enabled(enabled), .cfg_update(cfg_update),
        .h_total(h_total), .h_sync_start(h_sync_start), .h_sync_end(h_sync_end),
        .h_active_start(h_active_start), .h_active_end(h_active_end), .h_pol(h_pol),
        .v_total(v_total), .v_sync_start(v_sync_start), .v_sync_end(v_sync_end),
        .v_active_start(v_active_start), .v_active_end(v_active_end), .v_pol(v_pol),
        .irq_line(irq_line), .h_sync(h_sync), .v_sync(v_sync), .h_active(h_active),
        .v_active(v_active), .de(de), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .line_start(line_start), .frame_start(frame_start), .line_irq(line_irq),
        .cfg_pending(cfg_pending)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // The raster is a linear position p within a frame of H*V clocks;
    // x = p mod H, y = p div H.
    int   p;
    bit   m_pending;
    int   s_ht, s_hss, s_hse, s_has, s_hae, s_vt, s_vss, s_vse, s_vas, s_vae, s_irq;
    bit   s_hp, s_vp;
    logic [31:0] m_outs;

    function automatic int frame_len();
        int hh, vv;
        hh = (s_ht <= 1) ? 1 : s_ht;
        vv = (s_vt <= 1) ? 1 : s_vt;
        return hh * vv;
    endfunction

    function automatic logic [31:0] model_outs(bit en_i);
        int hh, x, y;
        bit ha, va, hs_in, vs_in, de_v;
        logic [11:0] px, py;
        if (!en_i) return {~s_hp, ~s_vp, 30'b0};
        hh = (s_ht <= 1) ? 1 : s_ht;
        x = p % hh;
        y = p / hh;
        hs_in = (x >= s_hss) && (x < s_hse);
        vs_in = (y >= s_vss) && (y < s_vse);
        ha = (x >= s_has) && (x < s_hae);
        va = (y >= s_vas) && (y < s_vae);
        de_v = ha && va;
        px = de_v ? 12'(x - s_has) : 12'd0;
        py = de_v ? 12'(y - s_vas) : 12'd0;
        return {hs_in ? s_hp : ~s_hp, vs_in ? s_vp : ~s_vp, ha, va, de_v,
                (x == 0), (x == 0) && (y == 0), (x == 0) && (y == s_irq), px, py};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            p <= 0; m_pending <= 1'b0; m_outs <= {2'b11, 30'b0};
            s_ht <= 0; s_hss <= 0; s_hse <= 0; s_has <= 0; s_hae <= 0; s_hp <= 1'b0;
            s_vt <= 0; s_vss <= 0; s_vse <= 0; s_vas <= 0; s_vae <= 0; s_vp <= 1'b0;
            s_irq <= 0;
        end else begin
            m_outs <= model_outs(enabled);
            if ((m_pending || cfg_update) && (!enabled || p == frame_len() - 1)) begin
                m_pending <= 1'b0;
                s_ht <= int'(h_total); s_hss <= int'(h_sync_start); s_hse <= int'(h_sync_end);
                s_has <= int'(h_active_start); s_hae <= int'(h_active_end); s_hp <= h_pol;
                s_vt <= int'(v_total); s_vss <= int'(v_sync_start); s_vse <= int'(v_sync_end);
                s_vas <= int'(v_active_start); s_vae <= int'(v_active_end); s_vp <= v_pol;
                s_irq <= int'(irq_line);
            end else if (cfg_update) begin
                m_pending <= 1'b1;
            end
            p <= (!enabled || p == frame_len() - 1) ? 0 : p + 1;
        end
    end

    logic [32:0] obs, exp_vec;
    assign obs = {h_sync, v_sync, h_active, v_active, de, line_start, frame_start,
                  line_irq, cfg_pending, pixel_x, pixel_y};
    assign exp_vec = {m_outs[31:24], m_pending, m_outs[23:0]};

    // ---------------- stimulus helpers ----------------
    task automatic set_mode(input int ht, hss, hse, has, hae, input bit hp,
                            input int vt, vss, vse, vas, vae, input bit vp, input int irq);
        h_total = CW'(ht); h_sync_start = CW'(hss); h_sync_end = CW'(hse);
        h_active_start = CW'(has); h_active_end = CW'(hae); h_pol = hp;
        v_total = CW'(vt); v_sync_start = CW'(vss); v_sync_end = CW'(vse);
        v_active_start = CW'(vas); v_active_end = CW'(vae); v_pol = vp;
        irq_line = CW'(irq);
    endtask

    // Load the current inputs while idle, then start running from origin
    task automatic load_idle_then_enable();
        enabled = 1'b0;
        cfg_update = 1'b1;
        @(negedge clk);
        cfg_update = 1'b0;
        enabled = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; enabled = 1'b0; cfg_update = 1'b0;
        set_mode(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_total++;
            if (obs !== RESET_VEC) $display("FAIL reset_state cyc=%0d got=%h exp=%h", i, obs, RESET_VEC);
            else n_pass++;
        end
        reset = 1'b1;
    endtask

    task automatic test_vga_640();
        int hs_low = 0, ls_cnt = 0, de_cnt = 0, fs_cnt = 0, max_x = 0, max_y = 0;
        set_mode(800, 656, 752, 0, 640, 0, 525, 490, 492, 0, 480, 0, 1000);
        load_idle_then_enable();
        for (int i = 0; i < 2400; i++) begin
            @(negedge clk);
            n_total++;
            if (obs !== exp_vec) $display("FAIL vga640_model cyc=%0d got=%h exp=%h", i, obs, exp_vec);
            else n_pass++;
            hs_low += (h_sync == 1'b0) ? 1 : 0;
            ls_cnt += line_start ? 1 : 0;
            fs_cnt += frame_start ? 1 : 0;
            de_cnt += de ? 1 : 0;
            if (de && int'(pixel_x) > max_x) max_x = int'(pixel_x);
            if (de && int'(pixel_y) > max_y) max_y = int'(pixel_y);
        end
        n_total += 6;
        if (hs_low !== 288) $display("FAIL vga640_hsync_low got=%0d exp=288", hs_low); else n_pass++;
        if (ls_cnt !== 3) $display("FAIL vga640_line_starts got=%0d exp=3", ls_cnt); else n_pass++;
        if (fs_cnt !== 1) $display("FAIL vga640_frame_starts got=%0d exp=1", fs_cnt); else n_pass++;
        if (de_cnt !== 1920) $display("FAIL vga640_de_count got=%0d exp=1920", de_cnt); else n_pass++;
        if (max_x !== 639) $display("FAIL vga640_max_x got=%0d exp=639", max_x); else n_pass++;
        if (max_y !== 2) $display("FAIL vga640_max_y got=%0d exp=2", max_y); else n_pass++;
    endtask

    task automatic test_frame_counts();
        int fs_cnt = 0, vs_hi = 0, de_cnt = 0, irq_cnt = 0, ls_cnt = 0;
        set_mode(40, 30, 34, 4, 36, 0, 30, 25, 27, 2, 26, 1, 100);
        load_idle_then_enable();
        for (int i = 0; i < 2400; i++) begin
            @(negedge clk);
            n_total++;
            if (obs !== exp_vec) $display("FAIL frames_model cyc=%0d got=%h exp=%h", i, obs, exp_vec);
            else n_pass++;
            fs_cnt += frame_start ? 1 : 0;
            vs_hi += v_sync ? 1 : 0;
            de_cnt += de ? 1 : 0;
            irq_cnt += line_irq ? 1 : 0;
            ls_cnt += line_start ? 1 : 0;
        end
        n_total += 5;
        if (fs_cnt !== 2) $display("FAIL frames_frame_starts got=%0d exp=2", fs_cnt); else n_pass++;
        if (vs_hi !== 160) $display("FAIL frames_vsync_active got=%0d exp=160", vs_hi); else n_pass++;
        if (de_cnt !== 1536) $display("FAIL frames_de_count got=%0d exp=1536", de_cnt); else n_pass++;
        if (irq_cnt !== 0) $display("FAIL frames_irq_beyond_total got=%0d exp=0", irq_cnt); else n_pass++;
        if (ls_cnt !== 60) $display("FAIL frames_line_starts got=%0d exp=60", ls_cnt); else n_pass++;
    endtask

    // Mid-frame request from the 40x30 mode to a 10x6 mode
    task automatic test_mode_switch();
        int since_ls = 0, pend_cnt = 0, ls_cnt = 0;
        bit found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            n_total++;
            if (obs !== exp_vec) $display("FAIL switch_pre_model cyc=%0d got=%h exp=%h", i, obs, exp_vec);
            else n_pass++;
            since_ls++;
            if (line_start) since_ls = 0;
        end
        set_mode(10, 8, 9, 2, 8, 0, 6, 4, 5, 1, 5, 0, 3);
        cfg_update = 1'b1;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            cfg_update = 1'b0;
            n_total++;
            if (obs !== exp_vec) $display("FAIL switch_wait_model cyc=%0d got=%h exp=%h", i, obs, exp_vec);
            else n_pass++;
            since_ls++;
            if (frame_start) begin
                found = 1'b1;
                n_total += 2;
                if (since_ls !== 40) $display("FAIL switch_last_old_line got=%0d exp=40", since_ls); else n_pass++;
                if (cfg_pending !== 1'b0) $display("FAIL switch_pending_cleared got=%b exp=0", cfg_pending); else n_pass++;
            end
            if (line_start) since_ls = 0;
            pend_cnt += cfg_pending ? 1 : 0;
        end
        n_total += 2;
        if (!found) $display("FAIL switch_timeout got=no_frame_start exp=frame_start"); else n_pass++;
        if (pend_cnt !== 1200 - 1 - 500) $display("FAIL switch_pending_span got=%0d exp=%0d", pend_cnt, 1200 - 1 - 500);
        else n_pass++;
        for (int i = 0; i < 59; i++) begin
            @(negedge clk);
            n_total++;
            if (obs !== exp_vec) $display("FAIL switch_post_model cyc=%0d got=%h exp=%h", i, obs, exp_vec);
            else n_pass++;
            since_ls++;
            if (line_start) begin
                ls_cnt++;
                n_total++;
                if (since_ls !== 10) $display("FAIL switch_new_line_len got=%0d exp=10", since_ls); else n_pass++;
                since_ls = 0;
            end
        end
        n_total++;
        if (ls_cnt !== 5) $display("FAIL switch_new_line_count got=%0d exp=5", ls_cnt); else n_pass++;
    endtask

    task automatic test_line_irq();
        int since_fs = 0, irq_cnt = 0;
        for (int i = 0; i < 180; i++) begin
            @(negedge clk);
            n_total++;
            if (obs !== exp_vec) $display("FAIL irq_model cyc=%0d got=%h exp=%h", i, obs, exp_vec);
            else n_pass++;
            if (frame_start) since_fs = 0; else since_fs++;
            if (line_irq) begin
                irq_cnt++;
                n_total++;
                if (since_fs !== 30) $display("FAIL irq_position got=%0d exp=30", since_fs); else n_pass++;
            end
        end
        n_total++;
        if (irq_cnt !== 3) $display("FAIL irq_count got=%0d exp=3", irq_cnt); else n_pass++;
        // irq_line beyond v_total: only the frame already in flight fires
        irq_line = CW'(6);
        cfg_update = 1'b1;
        irq_cnt = 0;
        for (int i = 0; i < 240; i++) begin
            @(negedge clk);
            cfg_update = 1'b0;
            n_total++;
            if (obs !== exp_vec) $display("FAIL irq_off_model cyc=%0d got=%h exp=%h", i, obs, exp_vec);
            else n_pass++;
            irq_cnt += line_irq ? 1 : 0;
        end
        n_total++;
        if (irq_cnt !== 1) $display("FAIL irq_off_count got=%0d exp=1", irq_cnt); else n_pass++;
    endtask

    task automatic test_degenerate();
        set_mode(12, 5, 5, 0, 12, 1, 3, 0, 1, 0, 3, 0, 0);
        load_idle_then_enable();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_total += 2;
            if (obs !== exp_vec) $display("FAIL degen_sync_model cyc=%0d got=%h exp=%h", i, obs, exp_vec);
            else n_pass++;
            if (h_sync !== 1'b0) $display("FAIL degen_hsync_const cyc=%0d got=%b exp=0", i, h_sync);
            else n_pass++;
        end
        set_mode(1, 0, 1, 0, 1, 0, 4, 0, 1, 0, 4, 0, 2);
        load_idle_then_enable();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_total += 3;
            if (obs !== exp_vec) $display("FAIL degen_htot1_model cyc=%0d got=%h exp=%h", i, obs, exp_vec);
            else n_pass++;
            if (line_start !== 1'b1) $display("FAIL degen_htot1_ls cyc=%0d got=%b exp=1", i, line_start);
            else n_pass++;
            if (pixel_x !== 12'd0) $display("FAIL degen_htot1_x cyc=%0d got=%0d exp=0", i, pixel_x);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        set_mode(40, 30, 34, 4, 36, 0, 30, 25, 27, 2, 26, 1, 7);
        load_idle_then_enable();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n_total++;
            if (obs !== exp_vec) $display("FAIL areset_pre_model cyc=%0d got=%h exp=%h", i, obs, exp_vec);
            else n_pass++;
        end
        set_mode(10, 8, 9, 2, 8, 0, 6, 4, 5, 1, 5, 0, 3);
        cfg_update = 1'b1;
        repeat (10) begin
            @(negedge clk);
            cfg_update = 1'b0;
        end
        n_total++;
        if (cfg_pending !== 1'b1) $display("FAIL areset_pending_set got=%b exp=1", cfg_pending); else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_total++;
        if (obs !== RESET_VEC) $display("FAIL areset_immediate got=%h exp=%h", obs, RESET_VEC); else n_pass++;
        @(negedge clk);
        n_total++;
        if (obs !== RESET_VEC) $display("FAIL areset_held got=%h exp=%h", obs, RESET_VEC); else n_pass++;
        reset = 1'b1;
        enabled = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if (obs !== exp_vec) $display("FAIL areset_idle_model cyc=%0d got=%h exp=%h", i, obs, exp_vec);
            else n_pass++;
        end
        enabled = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n_total += 3;
            if (obs !== exp_vec) $display("FAIL areset_run_model cyc=%0d got=%h exp=%h", i, obs, exp_vec);
            else n_pass++;
            if (frame_start !== 1'b1) $display("FAIL areset_zero_shadow_fs cyc=%0d got=%b exp=1", i, frame_start);
            else n_pass++;
            if (de !== 1'b0) $display("FAIL areset_zero_shadow_de cyc=%0d got=%b exp=0", i, de);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            n_total++;
            if (obs !== exp_vec) $display("FAIL random_model cyc=%0d got=%h exp=%h", i, obs, exp_vec);
            else n_pass++;
            if (i % 250 == 0)
                set_mode($urandom_range(0, 24), $urandom_range(0, 26), $urandom_range(0, 26),
                         $urandom_range(0, 26), $urandom_range(0, 26), 1'($urandom_range(0, 1)),
                         $urandom_range(0, 10), $urandom_range(0, 11), $urandom_range(0, 11),
                         $urandom_range(0, 11), $urandom_range(0, 11), 1'($urandom_range(0, 1)),
                         $urandom_range(0, 12));
            enabled = ($urandom_range(0, 199) != 0);
            cfg_update = ($urandom_range(0, 29) == 0);
        end
        cfg_update = 1'b0;
    endtask

    initial begin
        test_reset();
        test_vga_640();
        test_frame_counts();
        test_mode_switch();
        test_line_irq();
        test_degenerate();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
